// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

   // Default marker: "0011", first received bit is the MSB.
   localparam int unsigned DEF_PAT_LEN = 4;
   localparam logic [3:0]  DEF_PATTERN = 4'b0011;

   // Width of a counter that must hold 0..pat_len inclusive.
   function automatic int unsigned cnt_width(input int unsigned pat_len);
      return $clog2(pat_len + 1);
   endfunction

endpackage

// File: rtl/seq_det_0011.sv
// Serial bit-pattern detector.
// Shifts one bit of `a` per rising clk edge into a PAT_LEN-bit history and
// raises the registered flag `e` for one cycle whenever the last PAT_LEN
// samples equal PATTERN (oldest bit in the MSB).
// Ports:
//   clk - system clock, all state updates on its rising edge
//   clr - synchronous active-low reset, has priority over `a`
//   a   - serial data bit, sampled every rising edge
//   e   - registered detect flag, high for one cycle per match
module seq_det_0011
   import seq_det_pkg::*;
#(
   parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DEF_PATTERN),
   parameter bit                   OVERLAP = 1'b1
) (
   input  logic clk,
   input  logic clr,
   input  logic a,
   output logic e
);

   localparam int unsigned CNT_W = cnt_width(PAT_LEN);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAT_LEN);

   logic [PAT_LEN-1:0] hist;
   logic [PAT_LEN-1:0] next_hist;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   next_cnt;
   logic [CNT_W-1:0]   cnt_d;
   logic               match_c;

   // Next history, saturating fill count and match decision.
   always_comb begin
      next_hist = {hist[PAT_LEN-2:0], a};
      next_cnt  = cnt;
      cnt_d     = cnt;
      match_c   = 1'b0;

      if (cnt != CNT_FULL) begin
         next_cnt = cnt + CNT_W'(1);
      end

      // Only a completely filled window may report a match.
      match_c = (next_cnt == CNT_FULL) && (next_hist == PATTERN);

      // Without overlap the matched window is consumed entirely.
      if (match_c && !OVERLAP) begin
         cnt_d = '0;
      end else begin
         cnt_d = next_cnt;
      end
   end

   // State and output registers; reset wins over any value on `a`.
   always_ff @(posedge clk) begin
      if (!clr) begin
         hist <= '0;
         cnt  <= '0;
         e    <= 1'b0;
      end else begin
         hist <= next_hist;
         cnt  <= cnt_d;
         e    <= match_c;
      end
   end

endmodule

// File: tb/tb_seq_det_0011.sv
// Directed bench for seq_det_0011: default "0011" detector plus two
// "0101" instances (with and without overlap) sharing the same stimulus.
module tb_seq_det_0011;

   logic clk;
   logic clr;
   logic a;
   logic e;
   logic e_p0;
   logic e_p1;

   int total = 0;
   int bad   = 0;

   seq_det_0011 dut (
      .clk (clk),
      .clr (clr),
      .a   (a),
      .e   (e)
   );

   seq_det_0011 #(.PAT_LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b0)) dut_p0 (
      .clk (clk),
      .clr (clr),
      .a   (a),
      .e   (e_p0)
   );

   seq_det_0011 #(.PAT_LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b1)) dut_p1 (
      .clk (clk),
      .clr (clr),
      .a   (a),
      .e   (e_p1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

   task automatic check_e(input string tag, input logic exp);
      total++;
      assert (e === exp) else begin
         bad++;
         $error("FAIL %s: e=%b expected %b", tag, e, exp);
      end
   endtask

   // Drive one bit on the falling edge, check the default detector after the rising edge.
   task automatic step(input logic v, input logic exp, input string tag);
      @(negedge clk);
      clr = 1'b1;
      a   = v;
      @(posedge clk);
      #1;
      check_e(tag, exp);
   endtask

   // One edge with clr low; e must be 0 on all instances.
   task automatic rst_step(input logic v, input string tag);
      @(negedge clk);
      clr = 1'b0;
      a   = v;
      @(posedge clk);
      #1;
      check_e(tag, 1'b0);
      total++;
      assert (e_p0 === 1'b0 && e_p1 === 1'b0) else begin
         bad++;
         $error("FAIL %s_p: e_p0=%b e_p1=%b expected 0 0", tag, e_p0, e_p1);
      end
   endtask

   // Drive one bit and check all three detectors.
   task automatic step3(input logic v, input logic exp, input logic exp_p0,
                        input logic exp_p1, input string tag);
      step(v, exp, tag);
      total++;
      assert (e_p0 === exp_p0) else begin
         bad++;
         $error("FAIL %s_ov0: e=%b expected %b", tag, e_p0, exp_p0);
      end
      total++;
      assert (e_p1 === exp_p1) else begin
         bad++;
         $error("FAIL %s_ov1: e=%b expected %b", tag, e_p1, exp_p1);
      end
   endtask

   initial begin
      a   = 1'bx;
      clr = 1'b1;

      // 1. Reset at 5 ns with a=X.
      #2 clr = 1'b0;
      @(posedge clk);
      #1;
      check_e("reset", 1'b0);
      total++;
      assert (e_p0 === 1'b0 && e_p1 === 1'b0) else begin
         bad++;
         $error("FAIL reset_p: e_p0=%b e_p1=%b expected 0 0", e_p0, e_p1);
      end
      #1 clr = 1'b1;

      // 2. Single match, edges 15..45.
      step(1'b0, 1'b0, "m1_b0");
      step(1'b0, 1'b0, "m1_b1");
      step(1'b1, 1'b0, "m1_b2");
      step(1'b1, 1'b1, "m1_hit");

      // 3. Repeat, then hold a=1.
      step(1'b0, 1'b0, "m2_b0");
      step(1'b0, 1'b0, "m2_b1");
      step(1'b1, 1'b0, "m2_b2");
      step(1'b1, 1'b1, "m2_hit");
      for (int i = 0; i < 11; i++) begin
         step(1'b1, 1'b0, "ones");
      end

      // 4. Near-miss stream: one pulse after the final bit.
      step(1'b0, 1'b0, "nm0");
      step(1'b1, 1'b0, "nm1");
      step(1'b0, 1'b0, "nm2");
      step(1'b0, 1'b0, "nm3");
      step(1'b0, 1'b0, "nm4");
      step(1'b1, 1'b0, "nm5");
      step(1'b0, 1'b0, "nm6");
      step(1'b0, 1'b0, "nm7");
      step(1'b1, 1'b0, "nm8");
      step(1'b1, 1'b1, "nm_hit");
      step(1'b0, 1'b0, "nm_after");

      // 5. Mid-pattern reset: the pending hit must be dropped.
      step(1'b0, 1'b0, "mr0");
      step(1'b0, 1'b0, "mr1");
      step(1'b1, 1'b0, "mr2");
      rst_step(1'b1, "mr_rst");
      step(1'b1, 1'b0, "mr_post");
      step(1'b0, 1'b0, "mr_f0");
      step(1'b0, 1'b0, "mr_f1");
      step(1'b1, 1'b0, "mr_f2");
      step(1'b1, 1'b1, "mr_hit");

      // 6. "0101" stream with and without overlap.
      rst_step(1'bx, "ov_rst");
      step3(1'b0, 1'b0, 1'b0, 1'b0, "ov1");
      step3(1'b1, 1'b0, 1'b0, 1'b0, "ov2");
      step3(1'b0, 1'b0, 1'b0, 1'b0, "ov3");
      step3(1'b1, 1'b0, 1'b1, 1'b1, "ov4");
      step3(1'b0, 1'b0, 1'b0, 1'b0, "ov5");
      step3(1'b1, 1'b0, 1'b0, 1'b1, "ov6");
      step3(1'b0, 1'b0, 1'b0, 1'b0, "ov7");
      step3(1'b1, 1'b0, 1'b1, 1'b1, "ov8");
      step3(1'b1, 1'b0, 1'b0, 1'b0, "ov9");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
